bkey_frame_rx: RTL and testbench



---
 rtl/bkey_frame_rx.sv | 211 +++++++++++++++++++++
 tb/tb_bkey_frame_rx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bkey_frame_rx.sv
// bkey_frame_rx: receiver for the keyboard-brightness serial key line.
// The line is synchronised, each frame's start/stop framing is validated,
// and a FRAME_BITS-wide code is deserialised LSB first. Each accepted code
// is presented with a one-cycle strobe. Brightness up/down codes are decoded
// into held key levels that time out after KEY_HOLD_CYCLES.
//
// Ports:
//   LPC_CLK33M_GMUX  in   clock, 33 MHz
//   LPCPLUS_RESET_L  in   asynchronous active-low reset
//   GMUX_RESET_L     in   asynchronous serial key line, idles high
//   frame_code       out  last accepted code
//   frame_valid      out  one-cycle strobe; frame_code updated in the same cycle
//   frame_err        out  one-cycle strobe when the stop bit is sampled low
//   key_up           out  brightness-up held level
//   key_down         out  brightness-down held level
//   busy             out  receiver is not idle
//
// Build option: define BKEY_GLITCH_FILTER_EN to put a 3-tap majority filter
// after the synchroniser. It rejects 1-cycle pulses and adds 2 cycles of
// latency.
module bkey_frame_rx #(
  parameter int unsigned BIT_PERIOD      = 2640,
  parameter int unsigned FRAME_BITS      = 14,
  parameter logic [FRAME_BITS-1:0] CODE_UP   = FRAME_BITS'(14'h1FFD),
  parameter logic [FRAME_BITS-1:0] CODE_DOWN = FRAME_BITS'(14'h1FFE),
  parameter int unsigned KEY_HOLD_CYCLES = 330000
) (
  input  logic                  LPC_CLK33M_GMUX,
  input  logic                  LPCPLUS_RESET_L,
  input  logic                  GMUX_RESET_L,
  output logic [FRAME_BITS-1:0] frame_code,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic                  key_up,
  output logic                  key_down,
  output logic                  busy
);

  localparam int unsigned TW = $clog2(BIT_PERIOD);
  localparam int unsigned IW = $clog2(FRAME_BITS);
  localparam int unsigned HW = $clog2(KEY_HOLD_CYCLES + 1);

  localparam logic [TW-1:0] HALF_LAST = TW'(BIT_PERIOD / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_PERIOD - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(FRAME_BITS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(KEY_HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(KEY_HOLD_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  sync1_q, sync2_q;
  logic                  line_prev_q;
  logic                  line_s;
  logic                  fall;
  logic [TW-1:0]         timer_q, timer_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] code_q, code_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  key_up_q, key_up_d;
  logic                  key_down_q, key_down_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic                  busy_q, busy_d;

  // Optional majority filter over the last three synchronised samples.
`ifdef BKEY_GLITCH_FILTER_EN
  logic [2:0] tap_q, tap_d;
  always_comb begin
    tap_d  = {tap_q[1:0], sync2_q};
    line_s = (tap_q[0] & tap_q[1]) | (tap_q[0] & tap_q[2]) | (tap_q[1] & tap_q[2]);
  end
`else
  always_comb line_s = sync2_q;
`endif

  assign fall = ~line_s & line_prev_q;

  // Next-state, datapath and output logic.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    code_d     = code_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    key_up_d   = key_up_q;
    key_down_d = key_down_q;
    hold_d     = hold_q;

    // Key hold timeout; saturating counter runs only while a key is held.
    if (key_up_q | key_down_q) begin
      if (hold_q == HOLD_LAST) begin
        key_up_d   = 1'b0;
        key_down_d = 1'b0;
        hold_d     = '0;
      end else if (hold_q != HOLD_MAX) begin
        hold_d = hold_q + HW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (fall) state_d = START;
      end

      // Re-check the line half a bit after the edge to reject glitches.
      START: begin
        if (timer_q == HALF_LAST) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = line_s ? IDLE : DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      // Mid-bit samples shift in from the top so bit 0 ends up LSB.
      DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          shift_d = {line_s, shift_q[FRAME_BITS-1:1]};
          if (idx_q == IDX_LAST) state_d = STOP;
          else                   idx_d   = idx_q + IW'(1);
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      // Decoded key set here overrides a same-cycle hold expiry.
      STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          state_d = IDLE;
          if (line_s) begin
            valid_d    = 1'b1;
            code_d     = shift_q;
            key_up_d   = (shift_q == CODE_UP);
            key_down_d = (shift_q == CODE_DOWN);
            hold_d     = '0;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // All state; synchroniser and filter taps reset to the idle-high level.
  always_ff @(posedge LPC_CLK33M_GMUX or negedge LPCPLUS_RESET_L) begin
    if (!LPCPLUS_RESET_L) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      line_prev_q <= 1'b1;
`ifdef BKEY_GLITCH_FILTER_EN
      tap_q       <= 3'b111;
`endif
      state_q     <= IDLE;
      timer_q     <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      code_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      key_up_q    <= 1'b0;
      key_down_q  <= 1'b0;
      hold_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= GMUX_RESET_L;
      sync2_q     <= sync1_q;
      line_prev_q <= line_s;
`ifdef BKEY_GLITCH_FILTER_EN
      tap_q       <= tap_d;
`endif
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      key_up_q    <= key_up_d;
      key_down_q  <= key_down_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
    end
  end

  assign frame_code  = code_q;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign key_up      = key_up_q;
  assign key_down    = key_down_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_bkey_frame_rx.sv
// Directed bench for bkey_frame_rx with a shortened bit period and hold time.
module tb_bkey_frame_rx;

  localparam int unsigned BP      = 20;
  localparam int unsigned FB      = 14;
  localparam int unsigned KHC     = 1500;
  localparam int unsigned REFRESH = 1360;
`ifdef BKEY_GLITCH_FILTER_EN
  localparam int unsigned FILT = 2;
`else
  localparam int unsigned FILT = 0;
`endif
  // Cycles from driving the start edge to the frame strobe.
  localparam int unsigned LAT      = 2 + BP / 2 + (FB + 1) * BP + 1 + FILT;
  localparam int unsigned STOP_B2B = LAT + 1 - (FB + 1) * BP;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          line;
  logic [FB-1:0] frame_code;
  logic          frame_valid, frame_err, key_up, key_down, busy;

  int vectors     = 0;
  int miscompares = 0;
  int n_valid     = 0;
  int n_err       = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_valid === 1'b1) n_valid <= n_valid + 1;
    if (frame_err === 1'b1)   n_err   <= n_err + 1;
  end

  bkey_frame_rx #(
    .BIT_PERIOD      (BP),
    .FRAME_BITS      (FB),
    .CODE_UP         (14'h1FFD),
    .CODE_DOWN       (14'h1FFE),
    .KEY_HOLD_CYCLES (KHC)
  ) dut (
    .LPC_CLK33M_GMUX (clk),
    .LPCPLUS_RESET_L (rst_n),
    .GMUX_RESET_L    (line),
    .frame_code      (frame_code),
    .frame_valid     (frame_valid),
    .frame_err       (frame_err),
    .key_up          (key_up),
    .key_down        (key_down),
    .busy            (busy)
  );

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Start bit, FB data bits LSB first, then the stop level for stop_cycles.
  task automatic drive_frame(input logic [FB-1:0] code, input logic stop, input int stop_cycles);
    line = 1'b0;
    wait_cycles(BP);
    for (int i = 0; i < FB; i++) begin
      line = code[i];
      wait_cycles(BP);
    end
    line = stop;
    wait_cycles(stop_cycles);
    line = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    line  = 1'b1;
    wait_cycles(3);
    vectors++; if (frame_code !== 14'h0) begin miscompares++; $display("FAIL rst_code: got %h want 0000", frame_code); end
    vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", frame_valid); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b want 0", frame_err); end
    vectors++; if (key_up !== 1'b0) begin miscompares++; $display("FAIL rst_key_up: got %b want 0", key_up); end
    vectors++; if (key_down !== 1'b0) begin miscompares++; $display("FAIL rst_key_down: got %b want 0", key_down); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    wait_cycles(5);
  endtask

  task automatic test_up_frame;
    fork
      drive_frame(14'h1FFD, 1'b1, BP);
      begin
        wait_cycles(LAT - 1);
        vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL up_early: got %b want 0", frame_valid); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL up_busy: got %b want 1", busy); end
        wait_cycles(1);
        vectors++; if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL up_valid: got %b want 1", frame_valid); end
        vectors++; if (frame_code !== 14'h1FFD) begin miscompares++; $display("FAIL up_code: got %h want 1ffd", frame_code); end
        vectors++; if (key_up !== 1'b1) begin miscompares++; $display("FAIL up_key_up: got %b want 1", key_up); end
        vectors++; if (key_down !== 1'b0) begin miscompares++; $display("FAIL up_key_down: got %b want 0", key_down); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL up_idle: got %b want 0", busy); end
        wait_cycles(1);
        vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL up_one_cycle: got %b want 0", frame_valid); end
      end
    join
    wait_cycles(5);
  endtask

  task automatic test_back_to_back;
    fork
      begin
        drive_frame(14'h1FFE, 1'b1, STOP_B2B);
        drive_frame(14'h0123, 1'b1, BP);
      end
      begin
        wait_cycles(LAT);
        vectors++; if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid1: got %b want 1", frame_valid); end
        vectors++; if (frame_code !== 14'h1FFE) begin miscompares++; $display("FAIL b2b_code1: got %h want 1ffe", frame_code); end
        vectors++; if (key_down !== 1'b1) begin miscompares++; $display("FAIL b2b_key_down1: got %b want 1", key_down); end
        vectors++; if (key_up !== 1'b0) begin miscompares++; $display("FAIL b2b_key_up1: got %b want 0", key_up); end
        wait_cycles(LAT + 1);
        vectors++; if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid2: got %b want 1", frame_valid); end
        vectors++; if (frame_code !== 14'h0123) begin miscompares++; $display("FAIL b2b_code2: got %h want 0123", frame_code); end
        vectors++; if (key_down !== 1'b0) begin miscompares++; $display("FAIL b2b_key_down2: got %b want 0", key_down); end
        vectors++; if (key_up !== 1'b0) begin miscompares++; $display("FAIL b2b_key_up2: got %b want 0", key_up); end
      end
    join
    wait_cycles(5);
  endtask

  task automatic test_glitch;
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    fork
      begin
        line = 1'b0;
        wait_cycles(BP / 4);
        line = 1'b1;
      end
      begin
        wait_cycles(2 + FILT + BP / 2);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL glitch_busy: got %b want 1", busy); end
        wait_cycles(1);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_idle: got %b want 0", busy); end
      end
    join
    wait_cycles(3 * BP);
    vectors++; if (n_valid !== v0) begin miscompares++; $display("FAIL glitch_no_valid: got %0d want %0d", n_valid, v0); end
    vectors++; if (n_err !== e0) begin miscompares++; $display("FAIL glitch_no_err: got %0d want %0d", n_err, e0); end
  endtask

  task automatic test_stop_err;
    fork
      begin
        drive_frame(14'h1FFE, 1'b1, BP);
        drive_frame(14'h0155, 1'b0, BP);
      end
      begin
        wait_cycles(LAT);
        vectors++; if (key_down !== 1'b1) begin miscompares++; $display("FAIL err_pre_key_down: got %b want 1", key_down); end
        wait_cycles((FB + 2) * BP);
        vectors++; if (frame_err !== 1'b1) begin miscompares++; $display("FAIL err_strobe: got %b want 1", frame_err); end
        vectors++; if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL err_no_valid: got %b want 0", frame_valid); end
        vectors++; if (frame_code !== 14'h1FFE) begin miscompares++; $display("FAIL err_code_kept: got %h want 1ffe", frame_code); end
        vectors++; if (key_down !== 1'b1) begin miscompares++; $display("FAIL err_key_kept: got %b want 1", key_down); end
        wait_cycles(1);
        vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL err_one_cycle: got %b want 0", frame_err); end
      end
    join
    wait_cycles(5);
  endtask

  task automatic test_hold;
    fork
      drive_frame(14'h1FFD, 1'b1, BP);
      begin
        wait_cycles(LAT);
        vectors++; if (key_up !== 1'b1) begin miscompares++; $display("FAIL hold_rise: got %b want 1", key_up); end
        wait_cycles(KHC - 1);
        vectors++; if (key_up !== 1'b1) begin miscompares++; $display("FAIL hold_last: got %b want 1", key_up); end
        wait_cycles(1);
        vectors++; if (key_up !== 1'b0) begin miscompares++; $display("FAIL hold_expire: got %b want 0", key_up); end
      end
    join
    wait_cycles(5);
    fork
      begin
        drive_frame(14'h1FFD, 1'b1, BP);
        wait_cycles(REFRESH - (FB + 2) * BP);
        drive_frame(14'h1FFD, 1'b1, BP);
      end
      begin
        wait_cycles(LAT);
        vectors++; if (key_up !== 1'b1) begin miscompares++; $display("FAIL refresh_rise: got %b want 1", key_up); end
        wait_cycles(KHC);
        vectors++; if (key_up !== 1'b1) begin miscompares++; $display("FAIL refresh_extended: got %b want 1", key_up); end
        wait_cycles(REFRESH - 1);
        vectors++; if (key_up !== 1'b1) begin miscompares++; $display("FAIL refresh_last: got %b want 1", key_up); end
        wait_cycles(1);
        vectors++; if (key_up !== 1'b0) begin miscompares++; $display("FAIL refresh_expire: got %b want 0", key_up); end
      end
    join
    wait_cycles(5);
  endtask

  // Aborted frame has only ones after bit 7 so the released receiver sees no edge.
  task automatic test_reset_midframe;
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    fork
      drive_frame(14'h3F80, 1'b1, BP);
      begin
        wait_cycles(BP + 7 * BP + BP / 2);
        rst_n = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", busy); end
        vectors++; if (key_up !== 1'b0) begin miscompares++; $display("FAIL midrst_key_up: got %b want 0", key_up); end
        wait_cycles(2);
        rst_n = 1'b1;
      end
    join
    wait_cycles(2 * BP);
    vectors++; if (n_valid !== v0) begin miscompares++; $display("FAIL midrst_no_valid: got %0d want %0d", n_valid, v0); end
    vectors++; if (n_err !== e0) begin miscompares++; $display("FAIL midrst_no_err: got %0d want %0d", n_err, e0); end
    vectors++; if (frame_code !== 14'h0) begin miscompares++; $display("FAIL midrst_code: got %h want 0000", frame_code); end
    fork
      drive_frame(14'h1FFE, 1'b1, BP);
      begin
        wait_cycles(LAT);
        vectors++; if (frame_valid !== 1'b1) begin miscompares++; $display("FAIL midrst_valid: got %b want 1", frame_valid); end
        vectors++; if (frame_code !== 14'h1FFE) begin miscompares++; $display("FAIL midrst_code2: got %h want 1ffe", frame_code); end
        vectors++; if (key_down !== 1'b1) begin miscompares++; $display("FAIL midrst_key_down: got %b want 1", key_down); end
      end
    join
    wait_cycles(5);
  endtask

`ifdef BKEY_GLITCH_FILTER_EN
  task automatic test_pulse_filter;
    logic seen;
    seen = 1'b0;
    line = 1'b0;
    wait_cycles(1);
    line = 1'b1;
    for (int i = 0; i < 2 * BP; i++) begin
      if (busy !== 1'b0) seen = 1'b1;
      wait_cycles(1);
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL pulse_busy: got %b want 0", seen); end
  endtask
`endif

  initial begin
    test_reset();
    test_up_frame();
    test_back_to_back();
    test_glitch();
    test_stop_err();
    test_hold();
    test_reset_midframe();
`ifdef BKEY_GLITCH_FILTER_EN
    test_pulse_filter();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
